// File: rtl/adc_pkg.sv
// Shared constants and the channel-to-result mapping
// for the ADC128S-style SPI converter model.
package adc_pkg;

    localparam logic [2:0] CH_LFT  = 3'd0;
    localparam logic [2:0] CH_RGHT = 3'd4;
    localparam logic [2:0] CH_BATT = 3'd5;

    localparam int FRAME_BITS = 16;
    localparam int DATA_BITS  = 12;
    localparam int CNT_W      = 5;

    function automatic logic [DATA_BITS-1:0] sel_result(
        input logic [2:0]           ch,
        input logic [DATA_BITS-1:0] lft,
        input logic [DATA_BITS-1:0] rght,
        input logic [DATA_BITS-1:0] batt
    );
        logic [DATA_BITS-1:0] v;
        v = '0;
        unique case (ch)
            CH_LFT:  v = lft;
            CH_RGHT: v = rght;
            CH_BATT: v = batt;
            default: v = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/adc128s_model_if.sv
// SPI pins between the A2D master and the converter model.
interface adc128s_model_if;
    logic SS_n;
    logic SCLK;
    logic MOSI;
    logic MISO;

    modport master (output SS_n, output SCLK, output MOSI, input MISO);
    modport slave  (input SS_n, input SCLK, input MOSI, output MISO);
endinterface

// File: rtl/adc128s_model_sync.sv
// Multi-lane double-flop synchronizer; the low EW lanes
// also get a history flop for rise/fall detection.
module spi_edge_sync #(
    parameter int             W       = 3,
    parameter int             EW      = 2,
    parameter logic [W-1:0]   RST_VAL = '1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [W-1:0]  i_d,
    output logic [W-1:0]  o_q,
    output logic [EW-1:0] o_rise,
    output logic [EW-1:0] o_fall
);

    logic [W-1:0]  r_meta;
    logic [W-1:0]  r_q;
    logic [EW-1:0] r_hist;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= RST_VAL;
            r_q    <= RST_VAL;
            r_hist <= RST_VAL[EW-1:0];
        end else begin
            r_meta <= i_d;
            r_q    <= r_meta;
            r_hist <= r_q[EW-1:0];
        end
    end

    assign o_q    = r_q;
    assign o_rise = r_q[EW-1:0] & ~r_hist;
    assign o_fall = ~r_q[EW-1:0] & r_hist;

endmodule

// File: rtl/adc128s_model.sv
// Cycle-based ADC128S-style SPI converter: command in frame N
// selects the channel returned in frame N+1.
module adc128s_model
    import adc_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    adc128s_model_if.slave       spi,
    input  logic [DATA_BITS-1:0] batt_set,
    input  logic [DATA_BITS-1:0] lft_cell_set,
    input  logic [DATA_BITS-1:0] rght_cell_set
);

    logic [2:0] w_q;
    logic [1:0] w_rise;
    logic [1:0] w_fall;

    // lane order {MOSI, SCLK, SS_n}; SCLK and SS_n idle high
    spi_edge_sync #(
        .W       (3),
        .EW      (2),
        .RST_VAL (3'b011)
    ) u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_d    ({spi.MOSI, spi.SCLK, spi.SS_n}),
        .o_q    (w_q),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    logic w_ss_q;
    logic w_ss_rise;
    logic w_ss_fall;
    logic w_sck_rise;
    logic w_sck_fall;
    logic w_mosi;

    assign w_ss_q     = w_q[0];
    assign w_mosi     = w_q[2];
    assign w_ss_rise  = w_rise[0];
    assign w_ss_fall  = w_fall[0];
    assign w_sck_rise = w_rise[1];
    assign w_sck_fall = w_fall[1];

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);

    logic [FRAME_BITS-1:0] r_tx;
    // the top command bit is never consulted, so it is not kept
    logic [FRAME_BITS-2:0] r_rx;
    logic [CNT_W-1:0]      r_cnt;
    logic [2:0]            r_chan;
    logic                  r_active;
    logic                  r_armed;
    logic [1:0]            r_settle;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx     <= '0;
            r_rx     <= '0;
            r_cnt    <= '0;
            r_chan   <= CH_LFT;
            r_active <= 1'b0;
            r_armed  <= 1'b0;
            r_settle <= '0;
        end else begin
            r_settle <= {r_settle[0], 1'b1};
            // a frame already open at reset release is skipped
            if (r_settle[1] && w_ss_q)
                r_armed <= 1'b1;
            if (w_ss_fall && r_armed) begin
                r_active <= 1'b1;
                r_cnt    <= '0;
                r_tx     <= {4'b0000, sel_result(r_chan,
                             lft_cell_set, rght_cell_set,
                             batt_set)};
            end else if (w_ss_rise && r_active) begin
                r_active <= 1'b0;
                if (r_cnt == CNT_FULL)
                    r_chan <= r_rx[13:11];
            end else if (r_active) begin
                if (w_sck_rise && r_cnt != CNT_FULL) begin
                    r_rx  <= {r_rx[FRAME_BITS-3:0], w_mosi};
                    r_cnt <= r_cnt + 1'b1;
                end
                if (w_sck_fall) begin
                    if (r_cnt != '0 && r_cnt != CNT_FULL)
                        r_tx <= {r_tx[FRAME_BITS-2:0], 1'b0};
                    else if (r_cnt == CNT_FULL)
                        r_tx <= '0;
                end
            end
        end
    end

    assign spi.MISO = r_active & r_tx[FRAME_BITS-1];

endmodule

// File: tb/tb_adc128s_model.sv
// Directed bench for adc128s_model: vector table of
// full frames plus hand-written multi-cycle corner cases.
module tb_adc128s_model;

    logic        clk;
    logic        rst_n;
    logic [11:0] batt_set;
    logic [11:0] lft_cell_set;
    logic [11:0] rght_cell_set;

    adc128s_model_if spi();

    adc128s_model dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .spi           (spi),
        .batt_set      (batt_set),
        .lft_cell_set  (lft_cell_set),
        .rght_cell_set (rght_cell_set)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk;
    int n_err;

    typedef struct {
        logic [15:0] cmd;
        logic [11:0] lft;
        logic [11:0] rght;
        logic [11:0] batt;
        logic [15:0] exp;
    } vec_t;

    vec_t vt[10];

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name,
                       input logic [15:0] act,
                       input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic sclk_bit(input logic mosi, output logic miso);
        spi.SCLK = 1'b0;
        spi.MOSI = mosi;
        tick(8);
        miso = spi.MISO;
        spi.SCLK = 1'b1;
        tick(8);
    endtask

    task automatic frame(input logic [15:0] cmd,
                         input int n,
                         input int chg_at,
                         input logic [11:0] chg_val,
                         output logic [15:0] w,
                         output logic [1:0] ex);
        logic m;
        logic b;
        w = '0;
        ex = '0;
        spi.SS_n = 1'b0;
        tick(8);
        for (int i = 0; i < n; i++) begin
            b = (i < 16) ? cmd[15-i] : 1'b0;
            if (i == chg_at) lft_cell_set = chg_val;
            sclk_bit(b, m);
            if (i < 16) w = {w[14:0], m};
            else ex = {ex[0], m};
        end
        spi.SS_n = 1'b1;
        spi.MOSI = 1'b0;
        tick(8);
    endtask

    logic [15:0] w;
    logic [1:0]  ex;
    logic        m;
    logic        any_hi;

    initial begin
        n_chk = 0;
        n_err = 0;
        rst_n = 1'b0;
        spi.SS_n = 1'b1;
        spi.SCLK = 1'b1;
        spi.MOSI = 1'b0;
        lft_cell_set  = 12'h108;
        rght_cell_set = 12'h0F0;
        batt_set      = 12'hC00;

        vt[0] = '{16'h0000, 12'h108, 12'h0F0, 12'hC00, 16'h0108};
        vt[1] = '{16'h2000, 12'h108, 12'h0F0, 12'hC00, 16'h0108};
        vt[2] = '{16'h0000, 12'h108, 12'h0F0, 12'hC00, 16'h00F0};
        vt[3] = '{16'h2800, 12'h108, 12'h0F0, 12'hC00, 16'h0108};
        vt[4] = '{16'h3800, 12'h108, 12'h0F0, 12'hC00, 16'h0C00};
        vt[5] = '{16'h0000, 12'h108, 12'h0F0, 12'hC00, 16'h0000};
        vt[6] = '{16'h0800, 12'h108, 12'h0F0, 12'hC00, 16'h0108};
        vt[7] = '{16'hC7FF, 12'h108, 12'h0F0, 12'hC00, 16'h0000};
        vt[8] = '{16'h3000, 12'h1A5, 12'h0F0, 12'hC00, 16'h01A5};
        vt[9] = '{16'h0000, 12'h108, 12'h0F0, 12'hC00, 16'h0000};

        tick(4);
        chk("reset_miso", {15'd0, spi.MISO}, 16'h0000);
        rst_n = 1'b1;
        tick(4);

        for (int i = 0; i < 10; i++) begin
            lft_cell_set  = vt[i].lft;
            rght_cell_set = vt[i].rght;
            batt_set      = vt[i].batt;
            frame(vt[i].cmd, 16, -1, 12'h0, w, ex);
            chk($sformatf("vec%0d", i), w, vt[i].exp);
        end

        // input change mid-frame: captured value wins
        lft_cell_set = 12'h108;
        frame(16'h0000, 16, 6, 12'h180, w, ex);
        chk("midchg_cur", w, 16'h0108);
        frame(16'h0000, 16, -1, 12'h0, w, ex);
        chk("midchg_next", w, 16'h0180);

        // aborted frame keeps ch0
        frame(16'h2000, 8, -1, 12'h0, w, ex);
        frame(16'h0000, 16, -1, 12'h0, w, ex);
        chk("abort_next", w, 16'h0180);

        // extra SCLK edges
        frame(16'h2000, 18, -1, 12'h0, w, ex);
        chk("extra_word", w, 16'h0180);
        chk("extra_bits", {14'd0, ex}, 16'h0000);
        frame(16'h2000, 16, -1, 12'h0, w, ex);
        chk("extra_next", w, 16'h00F0);

        // reset in the middle of a frame returning ch4
        lft_cell_set = 12'hFFF;
        spi.SS_n = 1'b0;
        tick(8);
        for (int i = 0; i < 8; i++) sclk_bit(1'b0, m);
        spi.SCLK = 1'b0;
        tick(8);
        chk("pre_rst_miso", {15'd0, spi.MISO}, 16'h0001);
        rst_n = 1'b0;
        #1;
        chk("rst_miso", {15'd0, spi.MISO}, 16'h0000);
        spi.SCLK = 1'b1;
        tick(4);
        rst_n = 1'b1;
        any_hi = 1'b0;
        for (int i = 0; i < 6; i++) begin
            sclk_bit(1'b1, m);
            any_hi = any_hi | m;
        end
        chk("post_rst_ignored", {15'd0, any_hi}, 16'h0000);
        spi.SS_n = 1'b1;
        tick(8);
        frame(16'h0000, 16, -1, 12'h0, w, ex);
        chk("post_rst_frame", w, 16'h0FFF);
        frame(16'h2800, 16, -1, 12'h0, w, ex);
        chk("post_rst_frame2", w, 16'h0FFF);
        frame(16'h0000, 16, -1, 12'h0, w, ex);
        chk("post_rst_batt", w, 16'h0C00);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/adc128s_model.md
Name: adc128s_model

Overview:
Cycle-based behavioural model of an 8-channel, 12-bit SPI A/D converter (ADC128S-style).
- The Segway controller's A2D interface polls it for left load cell, right load cell and battery voltage.
- Values come from three 12-bit testbench-driven inputs.
- Each 16-bit SPI frame carries a channel-select command on MOSI. The same frame returns the conversion of the channel selected in the previous frame on MISO.

Parameters:
- CH_LFT, 3'd0, channel address returning lft_cell_set
- CH_RGHT, 3'd4, channel address returning rght_cell_set
- CH_BATT, 3'd5, channel address returning batt_set

Ports:
- clk  in  1  system clock; all logic in this domain
- rst_n  in  1  asynchronous active-low reset
- SS_n  in  1  active-low frame select from master
- SCLK  in  1  serial clock from master; idles high
- MOSI  in  1  serial command, MSB first
- MISO  out  1  serial result, MSB first
- batt_set  in  12  battery value
- lft_cell_set  in  12  left load-cell value
- rght_cell_set  in  12  right load-cell value

Behaviour:
- SS_n, SCLK and MOSI are double-flopped into clk, plus one history flop for edge detection. The master guarantees SCLK high and low phases of at least 4 clk each.
- SPI mode: SCLK idles high. Master changes MOSI on SCLK fall and samples MISO on SCLK rise. Slave samples MOSI on synchronized SCLK rise and shifts MISO on synchronized SCLK fall.
- Frame start (synchronized SS_n fall):
  - load 16-bit tx_shift = {4'b0000, result}, where result is the selected value for chan_ptr;
  - clear bit counter; MISO presents tx_shift[15] immediately.
- Result select:
  - CH_LFT → lft_cell_set, CH_RGHT → rght_cell_set, CH_BATT → batt_set;
  - every other address → 12'h000.
  - Inputs are captured at the frame start only; changes mid-frame do not affect the current frame.
- Each SCLK rise: rx_shift <= {rx_shift[14:0], MOSI}; bit counter increments, saturating at 16.
- Each SCLK fall: if the counter is 1..15, tx_shift shifts left by one, filling with 0.
- MISO = tx_shift[15] while SS_n low; MISO = 0 while SS_n high (no tri-state).
- Frame end (synchronized SS_n rise):
  - counter == 16: chan_ptr <= rx_shift[13:11] (bits 15:14 and 10:0 are don't-care);
  - counter != 16 (aborted frame): command discarded, chan_ptr unchanged.
- Extra SCLK edges beyond 16 in one frame: ignored; MISO stays 0.
- Pipeline latency: one frame. The first frame after reset returns channel 0 (chan_ptr reset value 3'd0).
- Reset, async active-low, including mid-frame:
  - chan_ptr = 0, counter = 0, tx_shift = 0, rx_shift = 0;
  - synchronizer flops set to SS_n = 1, SCLK = 1;
  - MISO = 0;
  - after reset release, a frame in progress is ignored until the next SS_n fall.

Decomposition:
- Shared package adc_pkg: channel address constants (CH_LFT/CH_RGHT/CH_BATT), FRAME_BITS = 16, DATA_BITS = 12.
- One natural sub-module: spi_edge_sync (the 3-flop synchronizer and edge detector for SCLK/SS_n, reused for MOSI sampling). The rest stays in one block.

Test Plan:
- Reset, then one frame with MOSI cmd 16'h0000 and lft_cell_set = 12'h108 → MISO word 16'h0108 (chan_ptr reset = 0).
- Frame cmd 16'h2000 (ch4), then frame cmd 16'h0000 with rght_cell_set = 12'h0F0 → second frame returns 16'h00F0.
- Frame cmd 16'h2800 (ch5), batt_set = 12'hC00, then any frame → 16'h0C00. Follow with a frame selecting ch7 → the next frame returns 16'h0000.
- Change lft_cell_set 12'h108 → 12'h180 mid-frame while ch0 is selected → current frame returns 16'h0108; next frame returns 16'h0180.
- Frame cmd ch4 aborted after 8 SCLKs (SS_n rises early) → chan_ptr unchanged; the next full frame returns the previously selected channel.
- Assert rst_n low mid-frame → MISO = 0 at once. After release, a full frame returns the ch0 value.
